// File: rtl/z80_mem_wr16_seq.sv
// Z80-style 16-bit memory store sequencer.
// Runs one T1/T2/Tw/T3 write cycle per byte: the low byte goes to nn and,
// in word mode, the high byte goes to nn+1. It reports completion, or an
// abort on a wait timeout, with a one-cycle done pulse.
module z80_mem_wr16_seq #(
    parameter int TIMEOUT = 16                 // max consecutive Tw per byte, 1..255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_data,
    input  logic        req_word,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_mreq_n,
    output logic        bus_wr_n,
    input  logic        bus_wait_n,
    output logic        done,
    output logic        done_err,
    output logic [1:0]  bytes_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TW,
        S_T3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] lat_addr;
    logic [15:0] lat_data;
    logic        lat_word;
    logic        byte_idx;
    logic [7:0]  wait_cnt;
    logic        accept;
    logic        timeout_hit;
    logic        more_bytes;

    assign accept      = req_valid && req_ready;
    assign timeout_hit = (state == S_TW) && !bus_wait_n && (wait_cnt >= TIMEOUT_CNT);
    assign more_bytes  = !byte_idx && lat_word;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the bus-cycle sequence.
    // NOTE: the default assignment first keeps this block free of inferred
    // latches even when a branch below leaves state_nxt untouched.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_T1;
            S_T1:   state_nxt = S_T2;
            S_T2:   state_nxt = bus_wait_n ? S_T3 : S_TW;
            S_TW: begin
                if (bus_wait_n) begin
                    state_nxt = S_T3;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_T3:   state_nxt = more_bytes ? S_T1 : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes and handshake decoded from the current state.
    always_comb begin
        bus_mreq_n = 1'b1;
        bus_wr_n   = 1'b1;
        if (state == S_T2 || state == S_TW) begin
            bus_mreq_n = 1'b0;
            bus_wr_n   = 1'b0;
        end
        req_ready = (state == S_IDLE) && reset_n;
    end

    // Request latch, bus address/data, wait counter and completion status.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lat_addr      <= 16'h0000;
            lat_data      <= 16'h0000;
            lat_word      <= 1'b0;
            byte_idx      <= 1'b0;
            wait_cnt      <= 8'd0;
            bus_addr      <= 16'h0000;
            bus_dout      <= 8'h00;
            done          <= 1'b0;
            done_err      <= 1'b0;
            bytes_written <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_addr <= req_addr;
                        lat_data <= req_data;
                        lat_word <= req_word;
                        byte_idx <= 1'b0;
                        bus_addr <= req_addr;
                        bus_dout <= req_data[7:0];
                    end
                end
                S_T2: begin
                    if (!bus_wait_n) wait_cnt <= 8'd1;
                end
                S_TW: begin
                    if (timeout_hit) begin
                        done          <= 1'b1;
                        done_err      <= 1'b1;
                        bytes_written <= {1'b0, byte_idx};
                    end else if (!bus_wait_n) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_T3: begin
                    if (more_bytes) begin
                        byte_idx <= 1'b1;
                        bus_addr <= lat_addr + 16'd1;   // wraps mod 2^16
                        bus_dout <= lat_data[15:8];
                    end else begin
                        done          <= 1'b1;
                        done_err      <= 1'b0;
                        bytes_written <= byte_idx ? 2'd2 : 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
